siso_shift_controller: RTL and testbench
========================================

# siso_shift_controller

Sequencing controller for a DEPTH-stage serial-in/serial-out shift register. It accepts a parallel word over a valid/ready handshake and shifts the word into the SISO MSB-first. It then flushes the SISO and recaptures its serial output into a result word, returned over a second valid/ready handshake. It sits between a word-level producer/consumer and one SISO instance, owning that instance's enable, shift and serial-in pins. It serves as a delay line and loopback self-check.

## Interface
- DATA_WIDTH, 8, bits per word; ≥ 1
- DEPTH, 4, stage count of the controlled SISO; ≥ 1
- Clk_In  input  1  clock; all logic on rising edge
- Reset_In  input  1  synchronous, active-high reset
- Word_Valid_In  input  1  producer offers Word_Data_In
- Word_Ready_Out  output  1  high only in IDLE
- Word_Data_In  input  DATA_WIDTH  word to serialize
- Abort_In  input  1  cancel the current transaction
- SISO_Enable_Out  output  1  to SISO Enable_In
- SISO_Shift_Out  output  1  to SISO Shift_Data_Signal_In
- SISO_Serial_Data_Out  output  1  to SISO Serial_Data_In
- SISO_Serial_Data_In  input  1  from SISO Serial_Data_Out
- Result_Valid_Out  output  1  recaptured word available
- Result_Data_Out  output  DATA_WIDTH  recaptured word
- Result_Ready_In  input  1  consumer accepts the result
- Error_Out  output  1  result ≠ sent word; qualified by Result_Valid_Out
- Busy_Out  output  1  state ≠ IDLE

## Operation
- States: IDLE → SHIFT → FLUSH → LAST → RESULT → IDLE.
- IDLE:
  - Word_Ready_Out=1.
  - Accept on Word_Valid_In & Word_Ready_Out: latch the word into a TX register and a reference copy, clear the bit counter, go to SHIFT.
- SHIFT, DATA_WIDTH cycles:
  - SISO_Enable_Out=1, SISO_Shift_Out=1.
  - SISO_Serial_Data_Out = TX MSB; TX shifts left each cycle.
- FLUSH, DEPTH−1 cycles (skipped when DEPTH=1):
  - Enable=1, Shift=1, SISO_Serial_Data_Out=0.
- LAST, 1 cycle:
  - Enable=1, Shift=0; takes the final sample.
- Sampling:
  - Number the post-acceptance cycles j = 1 … DATA_WIDTH+DEPTH.
  - In cycle j, sample SISO_Serial_Data_In when j ≥ DEPTH+1.
  - Each sample shifts into the RX register LSB-in, so the first sampled bit ends as MSB. This gives exactly DATA_WIDTH samples.
- RESULT:
  - Result_Valid_Out=1; Result_Data_Out and Error_Out held stable.
  - On Result_Ready_In, go to IDLE.
- Abort_In in SHIFT/FLUSH/LAST/RESULT → IDLE next edge. No result is produced, a pending result is dropped, and SISO_Shift_Out is 0 from that edge on.
- Abort_In in IDLE is ignored; Abort_In has priority over Result_Ready_In.
- Word_Valid_In while Busy_Out=1 is not accepted; the producer holds its word.
- In IDLE all SISO_* outputs are 0.

## Timing
- Reset: state IDLE; Result_Valid_Out, Result_Data_Out, Error_Out, Busy_Out and all SISO_* outputs are 0; counters and registers cleared. Word_Ready_Out=1 from the first cycle after reset.
- Reset mid-transaction: same as above at the reset edge; the partial result is discarded.
- All outputs are registered or decoded from state only; no combinational input→output path.
- Latency: Result_Valid_Out rises DATA_WIDTH+DEPTH+1 cycles after the acceptance edge.
- Shift pulses per transaction: exactly DATA_WIDTH+DEPTH−1.
- Result handshake: data stable while Valid=1 and Ready=0. The handshake edge returns to IDLE, and Word_Ready_Out=1 the next cycle. Minimum issue interval is DATA_WIDTH+DEPTH+2 cycles.
- Bit counter width: $clog2(DATA_WIDTH+DEPTH+1). No wrap within a transaction.

## Configuration
- SISO_CTRL_LOOPBACK_CHECK_EN defined: the reference copy register and comparator are built. In RESULT, Error_Out = (Result_Data_Out ≠ reference).
- Not defined: no reference register; Error_Out tied 0. All other behaviour is identical.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=4, with a real SISO_4_Bit instance connected and Result_Ready_In=1.
- Reset, then send 0xA5 → Result_Valid_Out high 13 cycles after acceptance, Result_Data_Out=0xA5, Error_Out=0, exactly 11 SISO_Shift_Out pulses.
- Send 0x00 and 0xFF back-to-back with Word_Valid_In held high → second word accepted the cycle after the first result handshake; results 0x00 then 0xFF.
- Hold Result_Ready_In=0 for 5 cycles after the result of 0x3C → Result_Data_Out stays 0x3C and Word_Ready_Out stays 0; accepted on the 6th cycle.
- Assert Abort_In in SHIFT cycle 3 of word 0x81 → IDLE next edge; no Result_Valid_Out. The next word, 0x42, returns 0x42.
- Assert Reset_In in FLUSH → all outputs 0 the next cycle and Word_Ready_Out=1 after it. With the macro defined, force one SISO output bit inverted → Error_Out=1 with the result.

Source files
------------

// File: rtl/siso_shift_controller.sv
// Purpose: sequences one DEPTH-stage SISO. It serialises a word MSB-first, flushes the SISO, and recaptures the word.
// Latency: Result_Valid_Out is high in the (DATA_WIDTH+DEPTH+1)th cycle after the acceptance edge.
// Backpressure: Word_Ready_Out is high only in IDLE. The result is held stable until Result_Ready_In is seen.
//
// Ports:
//   Clk_In, Reset_In                   rising-edge clock, synchronous active-high reset
//   Word_Valid_In/Ready_Out/Data_In    word intake handshake
//   Abort_In                           drops the current transaction (ignored in IDLE)
//   SISO_Enable_Out/Shift_Out/
//   SISO_Serial_Data_Out/_In           pins of the controlled SISO
//   Result_Valid_Out/Data_Out/Ready_In recaptured word handshake
//   Error_Out                          recaptured word differs from sent word (qualified by valid)
//   Busy_Out                           controller not in IDLE
// Optional feature macro: SISO_CTRL_LOOPBACK_CHECK_EN builds the reference register and comparator.
module siso_shift_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Word_Valid_In,
  output logic                  Word_Ready_Out,
  input  logic [DATA_WIDTH-1:0] Word_Data_In,
  input  logic                  Abort_In,
  output logic                  SISO_Enable_Out,
  output logic                  SISO_Shift_Out,
  output logic                  SISO_Serial_Data_Out,
  input  logic                  SISO_Serial_Data_In,
  output logic                  Result_Valid_Out,
  output logic [DATA_WIDTH-1:0] Result_Data_Out,
  input  logic                  Result_Ready_In,
  output logic                  Error_Out,
  output logic                  Busy_Out
);

  localparam int CNT_W = $clog2(DATA_WIDTH + DEPTH + 1);

  // bit_cnt holds j-1 during post-acceptance cycle j.
  localparam logic [CNT_W-1:0] SHIFT_END    = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FLUSH_END    = CNT_W'(DATA_WIDTH + DEPTH - 2);
  localparam logic [CNT_W-1:0] SAMPLE_START = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FLUSH,
    ST_LAST,
    ST_RESULT
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_reg;
  logic [DATA_WIDTH-1:0] rx_reg;
  logic [DATA_WIDTH-1:0] rx_shifted;
  logic                  accept;
  logic                  in_xfer;

  assign accept  = (state == ST_IDLE) && Word_Valid_In;
  assign in_xfer = (state == ST_SHIFT) || (state == ST_FLUSH) || (state == ST_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (Word_Valid_In) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (Abort_In)                  state_nxt = ST_IDLE;
        else if (bit_cnt == SHIFT_END) state_nxt = (DEPTH > 1) ? ST_FLUSH : ST_LAST;
      end
      ST_FLUSH: begin
        if (Abort_In)                  state_nxt = ST_IDLE;
        else if (bit_cnt == FLUSH_END) state_nxt = ST_LAST;
      end
      ST_LAST: begin
        state_nxt = Abort_In ? ST_IDLE : ST_RESULT;
      end
      ST_RESULT: begin
        // Abort wins over the result handshake; both end in IDLE, but only the handshake delivers the word.
        if (Abort_In || Result_Ready_In) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The first sampled bit is the sent MSB, so shift in at the LSB and let it walk up.
  always_comb begin
    rx_shifted    = rx_reg << 1;
    rx_shifted[0] = SISO_Serial_Data_In;
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      tx_reg  <= '0;
      rx_reg  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tx_reg  <= Word_Data_In;
        rx_reg  <= '0;
        bit_cnt <= '0;
      end else if (in_xfer) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (state == ST_SHIFT) tx_reg <= tx_reg << 1;
        // The sent MSB needs DEPTH shifts to reach the SISO output.
        if (bit_cnt >= SAMPLE_START) rx_reg <= rx_shifted;
      end
    end
  end

  assign Word_Ready_Out       = (state == ST_IDLE);
  assign Busy_Out             = (state != ST_IDLE);
  assign SISO_Enable_Out      = in_xfer;
  assign SISO_Shift_Out       = (state == ST_SHIFT) || (state == ST_FLUSH);
  assign SISO_Serial_Data_Out = (state == ST_SHIFT) && tx_reg[DATA_WIDTH-1];
  assign Result_Valid_Out     = (state == ST_RESULT);
  assign Result_Data_Out      = rx_reg;

`ifdef SISO_CTRL_LOOPBACK_CHECK_EN
  logic [DATA_WIDTH-1:0] ref_reg;

  always_ff @(posedge Clk_In) begin
    if (Reset_In)    ref_reg <= '0;
    else if (accept) ref_reg <= Word_Data_In;
  end

  assign Error_Out = (state == ST_RESULT) && (rx_reg != ref_reg);
`else
  assign Error_Out = 1'b0;
`endif

endmodule

// File: tb/tb_siso_shift_controller.sv
module tb_siso_shift_controller;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = DW + DEPTH + 1;
  localparam int NSH   = DW + DEPTH - 1;
`ifdef SISO_CTRL_LOOPBACK_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          Clk_In = 1'b0;
  logic          Reset_In = 1'b1;
  logic          Word_Valid_In = 1'b0;
  logic          Word_Ready_Out;
  logic [DW-1:0] Word_Data_In = '0;
  logic          Abort_In = 1'b0;
  logic          SISO_Enable_Out;
  logic          SISO_Shift_Out;
  logic          SISO_Serial_Data_Out;
  logic          SISO_Serial_Data_In;
  logic          Result_Valid_Out;
  logic [DW-1:0] Result_Data_Out;
  logic          Result_Ready_In = 1'b1;
  logic          Error_Out;
  logic          Busy_Out;

  siso_shift_controller #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .Clk_In(Clk_In), .Reset_In(Reset_In),
    .Word_Valid_In(Word_Valid_In), .Word_Ready_Out(Word_Ready_Out), .Word_Data_In(Word_Data_In),
    .Abort_In(Abort_In),
    .SISO_Enable_Out(SISO_Enable_Out), .SISO_Shift_Out(SISO_Shift_Out),
    .SISO_Serial_Data_Out(SISO_Serial_Data_Out), .SISO_Serial_Data_In(SISO_Serial_Data_In),
    .Result_Valid_Out(Result_Valid_Out), .Result_Data_Out(Result_Data_Out),
    .Result_Ready_In(Result_Ready_In), .Error_Out(Error_Out), .Busy_Out(Busy_Out)
  );

  always #5 Clk_In = ~Clk_In;

  // Stand-in for the external DEPTH-stage SISO; flip inverts its serial output for fault injection.
  logic [DEPTH-1:0] siso_q;
  logic             flip = 1'b0;
  always @(posedge Clk_In) begin
    if (Reset_In)                              siso_q <= '0;
    else if (SISO_Enable_Out && SISO_Shift_Out) siso_q <= {siso_q[DEPTH-2:0], SISO_Serial_Data_Out};
  end
  assign SISO_Serial_Data_In = siso_q[DEPTH-1] ^ flip;

  int total_shifts = 0;
  always @(posedge Clk_In) if (SISO_Shift_Out) total_shifts <= total_shifts + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int shift_base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] word;
    int            stall;
    int            abort_j;   // 0 = no abort; else abort during post-acceptance cycle j
    int            flip_k;    // -1 = none; else corrupt sampled bit k (0 = MSB)
    bit            exp_valid;
    logic [DW-1:0] exp_data;
    int            exp_lat;
    int            exp_shifts;
    bit            exp_err;
  } vec_t;

  // Called at a negedge; returns at the negedge of post-acceptance cycle 1.
  task automatic accept(input logic [DW-1:0] w, input bit hold, output int waited);
    Word_Data_In  = w;
    Word_Valid_In = 1'b1;
    waited = 0;
    while (!Word_Ready_Out && waited < 100) begin
      @(negedge Clk_In);
      waited++;
    end
    chk("accept_ready", Word_Ready_Out, 1);
    shift_base = total_shifts;
    @(posedge Clk_In);
    @(negedge Clk_In);
    if (!hold) Word_Valid_In = 1'b0;
  endtask

  // Follows one transaction from cycle 1; returns at the negedge after handshake or abort.
  task automatic follow(input vec_t v);
    int  nv;
    int  lat;
    bit  hs;
    bit  done;
    nv = 0; lat = 0; hs = 0; done = 0;
    for (int j = 1; j <= 60 && !done; j++) begin
      Abort_In = (v.abort_j == j);
      flip     = (v.flip_k >= 0) && (j == DEPTH + 1 + v.flip_k);
      if (j == 1) begin
        chk("busy_c1", Busy_Out, 1);
        chk("ready_c1", Word_Ready_Out, 0);
      end
      if (v.abort_j > 0 && j == v.abort_j + 1) begin
        chk("abort_busy", Busy_Out, 0);
        chk("abort_shift", SISO_Shift_Out, 0);
        chk("abort_valid", Result_Valid_Out, 0);
        done = 1;
      end else if (hs) begin
        chk("post_hs_valid", Result_Valid_Out, 0);
        chk("post_hs_ready", Word_Ready_Out, 1);
        done = 1;
      end else if (Result_Valid_Out) begin
        nv++;
        if (nv == 1) lat = j;
        chk("result_data", Result_Data_Out, v.exp_data);
        chk("result_err", Error_Out, v.exp_err);
        chk("ready_while_result", Word_Ready_Out, 0);
        Result_Ready_In = (nv > v.stall);
        hs = Result_Ready_In;
      end
      if (!done) @(negedge Clk_In);
    end
    Abort_In = 1'b0;
    flip = 1'b0;
    Result_Ready_In = 1'b1;
    chk("txn_done", done, 1);
    chk("valid_seen", (nv > 0), v.exp_valid);
    if (v.exp_valid) begin
      chk("latency", lat, v.exp_lat);
      chk("valid_cycles", nv, v.stall + 1);
    end
    chk("shift_pulses", total_shifts - shift_base, v.exp_shifts);
  endtask

  vec_t vecs[5];
  vec_t rv;
  int   w;

  initial begin
    vecs[0] = '{8'hA5, 0, 0, -1, 1'b1, 8'hA5, 13, 11, 1'b0};
    vecs[1] = '{8'h3C, 5, 0, -1, 1'b1, 8'h3C, 13, 11, 1'b0};
    vecs[2] = '{8'h81, 0, 3, -1, 1'b0, 8'h00, 0, 3, 1'b0};
    vecs[3] = '{8'h42, 0, 0, -1, 1'b1, 8'h42, 13, 11, 1'b0};
    vecs[4] = '{8'h5A, 0, 0, 2, 1'b1, 8'h7A, 13, 11, CHK_EN};

    // Reset state
    repeat (3) @(negedge Clk_In);
    chk("rst_valid", Result_Valid_Out, 0);
    chk("rst_data", Result_Data_Out, 0);
    chk("rst_err", Error_Out, 0);
    chk("rst_busy", Busy_Out, 0);
    chk("rst_siso", {SISO_Enable_Out, SISO_Shift_Out, SISO_Serial_Data_Out}, 0);
    Reset_In = 1'b0;
    @(negedge Clk_In);
    chk("rst_ready", Word_Ready_Out, 1);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      accept(vecs[i].word, 1'b0, w);
      follow(vecs[i]);
    end

    // Back-to-back with Word_Valid_In held high
    accept(8'h00, 1'b1, w);
    Word_Data_In = 8'hFF;
    follow('{8'h00, 0, 0, -1, 1'b1, 8'h00, LAT, NSH, 1'b0});
    accept(8'hFF, 1'b0, w);
    chk("b2b_no_wait", w, 0);
    follow('{8'hFF, 0, 0, -1, 1'b1, 8'hFF, LAT, NSH, 1'b0});

    // Reset during FLUSH
    accept(8'h99, 1'b0, w);
    repeat (9) @(negedge Clk_In);
    chk("flush_busy", Busy_Out, 1);
    chk("flush_shift", SISO_Shift_Out, 1);
    chk("flush_sdo", SISO_Serial_Data_Out, 0);
    Reset_In = 1'b1;
    @(negedge Clk_In);
    chk("mrst_valid", Result_Valid_Out, 0);
    chk("mrst_data", Result_Data_Out, 0);
    chk("mrst_err", Error_Out, 0);
    chk("mrst_busy", Busy_Out, 0);
    chk("mrst_siso", {SISO_Enable_Out, SISO_Shift_Out, SISO_Serial_Data_Out}, 0);
    Reset_In = 1'b0;
    @(negedge Clk_In);
    chk("mrst_ready", Word_Ready_Out, 1);

    // Randomized transactions against the loopback model
    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(0, 2)) begin
        Abort_In = $urandom_range(0, 1);
        @(negedge Clk_In);
        chk("idle_abort_busy", Busy_Out, 0);
      end
      Abort_In = 1'b0;
      rv.word      = DW'($urandom);
      rv.stall     = $urandom_range(0, 3);
      rv.abort_j   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, LAT - 1) : 0;
      rv.flip_k    = -1;
      rv.exp_valid = (rv.abort_j == 0);
      rv.exp_data  = rv.word;
      rv.exp_lat   = LAT;
      rv.exp_shifts = (rv.abort_j == 0) ? NSH : ((rv.abort_j < NSH) ? rv.abort_j : NSH);
      rv.exp_err   = 1'b0;
      accept(rv.word, 1'b0, w);
      follow(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
